// File: rtl/spi_master_sched.sv
// spi_master_sched: two-requester mode-0 SPI master, 8-bit MSB-first; define SPI_SCHED_RR_EN for round-robin arbitration (default fixed priority)
module spi_master_sched #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [1:0] REQ,
    input  logic [7:0] TX_DATA0,
    input  logic [7:0] TX_DATA1,
    output logic [1:0] GNT,
    output logic [1:0] DONE,
    output logic [7:0] RX_DATA,
    output logic       BUSY,
    output logic       SCK,
    output logic       SS,
    output logic       MOSI,
    input  logic       MISO
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] HIGH  = 3'd2;
    localparam logic [2:0] LOW   = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;
    logic [2:0] state;
    logic [2:0] bits;
    logic [7:0] cnt;
    logic [7:0] tx_sel;
    logic [7:0] rx;
    logic [6:0] tx;
    logic       win;
    logic       who;
    logic       step;
`ifdef SPI_SCHED_RR_EN
    logic last;
    always_ff @(posedge PCLK)
        if (PRESET) last <= 1'b1;
        else if (state == IDLE && |REQ) last <= win;
    assign win = &REQ ? ~last : REQ[1];
`else
    assign win = ~REQ[0];
`endif
    assign tx_sel = win ? TX_DATA1 : TX_DATA0;
    // GAP runs one cycle short: the IDLE cycle that follows completes the SS high time
    assign step = (state == GAP) ? (cnt == 8'(SS_GAP - 2)) : (cnt == 8'(CLK_DIV - 1));
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            bits    <= 3'd0;
            tx      <= 7'd0;
            rx      <= 8'd0;
            who     <= 1'b0;
            GNT     <= 2'b00;
            DONE    <= 2'b00;
            RX_DATA <= 8'h00;
            BUSY    <= 1'b0;
            SCK     <= 1'b0;
            SS      <= 1'b1;
            MOSI    <= 1'b0;
        end else begin
            GNT  <= 2'b00;
            DONE <= 2'b00;
            cnt  <= (state == IDLE || step) ? 8'd0 : cnt + 8'd1;
            case (state)
                IDLE: if (|REQ) begin
                    who   <= win;
                    tx    <= tx_sel[6:0];
                    MOSI  <= tx_sel[7];
                    GNT   <= win ? 2'b10 : 2'b01;
                    SS    <= 1'b0;
                    BUSY  <= 1'b1;
                    bits  <= 3'd0;
                    state <= SETUP;
                end
                SETUP, LOW: if (step) begin
                    SCK   <= 1'b1;
                    state <= HIGH;
                end
                HIGH: if (step) begin
                    SCK   <= 1'b0;
                    rx    <= {rx[6:0], MISO};
                    tx    <= {tx[5:0], 1'b0};
                    MOSI  <= tx[6];
                    bits  <= bits + 3'd1;
                    state <= (bits == 3'd7) ? HOLD : LOW;
                end
                HOLD: if (step) begin
                    SS      <= 1'b1;
                    RX_DATA <= rx;
                    DONE    <= who ? 2'b10 : 2'b01;
                    MOSI    <= 1'b0;
                    BUSY    <= SS_GAP > 1;
                    state   <= (SS_GAP > 1) ? GAP : IDLE;
                end
                GAP: if (step) begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_sched.sv
// tb_spi_master_sched: two instances (CLK_DIV=4/SS_GAP=2 and CLK_DIV=1/SS_GAP=3) checked against a transfer-level model
module tb_spi_master_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst  [2] = '{1'b1, 1'b1};
    logic [1:0] req  [2] = '{2'b00, 2'b00};
    logic [7:0] tx0  [2] = '{8'h00, 8'h00};
    logic [7:0] tx1  [2] = '{8'h00, 8'h00};
    logic [7:0] sb   [2] = '{8'h00, 8'h00};
    logic [1:0] gnt  [2];
    logic [1:0] done [2];
    logic [7:0] rxd  [2];
    logic       busy [2];
    logic       sck  [2];
    logic       ss   [2];
    logic       mosi [2];
    logic [1:0] miso;
    logic [1:0] obs_w;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int last_w [2] = '{1, 1};
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_sched #(.CLK_DIV(4), .SS_GAP(2)) u0 (
        .PCLK(clk), .PRESET(rst[0]), .REQ(req[0]), .TX_DATA0(tx0[0]), .TX_DATA1(tx1[0]),
        .GNT(gnt[0]), .DONE(done[0]), .RX_DATA(rxd[0]), .BUSY(busy[0]), .SCK(sck[0]),
        .SS(ss[0]), .MOSI(mosi[0]), .MISO(miso[0]));
    spi_master_sched #(.CLK_DIV(1), .SS_GAP(3)) u1 (
        .PCLK(clk), .PRESET(rst[1]), .REQ(req[1]), .TX_DATA0(tx0[1]), .TX_DATA1(tx1[1]),
        .GNT(gnt[1]), .DONE(done[1]), .RX_DATA(rxd[1]), .BUSY(busy[1]), .SCK(sck[1]),
        .SS(ss[1]), .MOSI(mosi[1]), .MISO(miso[1]));

    // Mode-0 slave: presents sb MSB first, advancing after each SCK fall while selected
    for (genvar g = 0; g < 2; g++) begin : slave
        int   falls = 0;
        logic psck  = 1'b0;
        always @(negedge clk) begin
            falls <= ss[g] ? 0 : falls + ((psck && !sck[g]) ? 1 : 0);
            psck  <= sck[g];
        end
        assign miso[g] = (falls < 8) ? sb[g][3'(7 - falls)] : 1'b0;
    end

    function automatic logic [1:0] arb(input int i, input logic [1:0] r);
        int w;
`ifdef SPI_SCHED_RR_EN
        w = (r == 2'b11) ? 1 - last_w[i] : (r[1] ? 1 : 0);
`else
        w = r[0] ? 0 : 1;
`endif
        last_w[i] = w;
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic xfer(input int i, input int d, input int gap, input bit back, input bit drop,
                        input logic [1:0] exp_w, input logic [7:0] exp_tx, input logic [7:0] exp_rx);
        int n = 0;
        int e0, t, rises, falls, low, bad;
        logic ps, pm, pss;
        logic [7:0] got = 8'h00;
        do begin
            @(negedge clk);
            n++;
        end while (gnt[i] == 2'b00 && n < 300);
        obs_w = gnt[i];
        vectors++;
        if (gnt[i] !== exp_w) begin
            miscompares++;
            $display("FAIL gnt inst%0d: got %b want %b", i, gnt[i], exp_w);
        end
        if (gnt[i] == 2'b00) return;
        if (back) begin
            vectors++;
            if (n < gap) begin
                miscompares++;
                $display("FAIL ss_gap inst%0d: got %0d want >=%0d", i, n, gap);
            end
        end
        vectors++;
        if ({ss[i], busy[i], mosi[i]} !== {1'b0, 1'b1, exp_tx[7]}) begin
            miscompares++;
            $display("FAIL start inst%0d: ss/busy/mosi got %b%b%b want 01%b", i, ss[i], busy[i], mosi[i], exp_tx[7]);
        end
        e0 = cyc; t = 0; rises = 0; falls = 0; low = 1; bad = 0;
        ps = sck[i]; pm = mosi[i]; pss = ss[i];
        while (done[i] == 2'b00 && t < 17 * d + 4) begin
            @(negedge clk);
            if (drop && cyc == e0 + 1) req[i] = 2'b00;
            t = cyc - e0;
            if (sck[i] && !ps) begin
                rises++;
                got = {got[6:0], mosi[i]};
                if (t != (2 * rises - 1) * d) bad++;
            end
            if (!sck[i] && ps) begin
                falls++;
                if (t != 2 * falls * d) bad++;
            end
            if (mosi[i] !== pm && !(ps && !sck[i]) && ss[i] === pss) bad++;
            if (!ss[i]) low++;
            ps = sck[i]; pm = mosi[i]; pss = ss[i];
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL sck_mosi_timing inst%0d: got %0d violations want 0", i, bad);
        end
        vectors++;
        if (done[i] !== exp_w || t != 17 * d) begin
            miscompares++;
            $display("FAIL done inst%0d: got %b at +%0d want %b at +%0d", i, done[i], t, exp_w, 17 * d);
        end
        vectors++;
        if (rxd[i] !== exp_rx) begin
            miscompares++;
            $display("FAIL rx_data inst%0d: got %h want %h", i, rxd[i], exp_rx);
        end
        vectors++;
        if (got !== exp_tx || rises != 8) begin
            miscompares++;
            $display("FAIL mosi_byte inst%0d: got %h (%0d rises) want %h (8 rises)", i, got, rises, exp_tx);
        end
        vectors++;
        if (low != 17 * d) begin
            miscompares++;
            $display("FAIL ss_low inst%0d: got %0d want %0d", i, low, 17 * d);
        end
        vectors++;
        if ({ss[i], sck[i], mosi[i], busy[i]} !== {1'b1, 1'b0, 1'b0, gap > 1}) begin
            miscompares++;
            $display("FAIL end_state inst%0d: ss/sck/mosi/busy got %b%b%b%b", i, ss[i], sck[i], mosi[i], busy[i]);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        vectors++;
        if ({sck[i], ss[i], mosi[i], gnt[i], done[i], busy[i], rxd[i]} !== 16'h4000) begin
            miscompares++;
            $display("FAIL %s inst%0d: sck/ss/mosi/gnt/done/busy/rx got %b %b %b %b %b %b %h", tag, i,
                     sck[i], ss[i], mosi[i], gnt[i], done[i], busy[i], rxd[i]);
        end
    endtask

    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        repeat (2) @(negedge clk);
        rst[i] = 1'b0;
        last_w[i] = 1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_idle(0, "reset");
        check_idle(1, "reset");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        req[0] = 2'b01; tx0[0] = 8'hA5; tx1[0] = 8'h5A; sb[0] = 8'h3C;
        xfer(0, 4, 2, 0, 0, arb(0, 2'b01), 8'hA5, 8'h3C);
        req[0] = 2'b00;
    endtask

    task automatic test_contention;
        logic [3:0] seq = 4'b0000;
        logic [1:0] w;
        do_reset(0);
        req[0] = 2'b11; tx0[0] = 8'h11; tx1[0] = 8'h22;
        for (int k = 0; k < 4; k++) begin
            sb[0] = 8'($urandom);
            w = arb(0, 2'b11);
            xfer(0, 4, 2, k > 0, 0, w, w[1] ? 8'h22 : 8'h11, sb[0]);
            seq[k] = obs_w[1];
        end
        req[0] = 2'b00;
        vectors++;
`ifdef SPI_SCHED_RR_EN
        if (seq !== 4'b1010) begin
`else
        if (seq !== 4'b0000) begin
`endif
            miscompares++;
            $display("FAIL grant_order: got %b", seq);
        end
    endtask

    task automatic test_abort;
        int n = 0;
        int e0;
        int seen = 0;
        req[0] = 2'b01; tx0[0] = 8'($urandom); sb[0] = 8'($urandom) | 8'h01;
        do begin
            @(negedge clk);
            n++;
        end while (gnt[0] == 2'b00 && n < 300);
        vectors++;
        if (gnt[0] !== 2'b01) begin
            miscompares++;
            $display("FAIL abort_gnt: got %b want 01", gnt[0]);
        end
        e0 = cyc;
        req[0] = 2'b00;
        while (cyc < e0 + 29) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        last_w[0] = 1;
        check_idle(0, "abort");
        repeat (80) begin
            @(negedge clk);
            if (done[0] != 2'b00 || !ss[0]) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
        end
        req[0] = 2'b01;
        xfer(0, 4, 2, 0, 0, arb(0, 2'b01), tx0[0], sb[0]);
        req[0] = 2'b00;
    endtask

    task automatic test_fast;
        req[1] = 2'b10; tx0[1] = 8'h00; tx1[1] = 8'hFF; sb[1] = 8'h00;
        xfer(1, 1, 3, 0, 0, arb(1, 2'b10), 8'hFF, 8'h00);
        req[1] = 2'b00;
    endtask

    task automatic test_req_drop;
        repeat (4) @(negedge clk);
        req[0] = 2'b01; tx0[0] = 8'($urandom); sb[0] = 8'($urandom);
        xfer(0, 4, 2, 0, 1, arb(0, 2'b01), tx0[0], sb[0]);
        req[0] = 2'b00;
    endtask

    task automatic test_random(input int i, input int d, input int gap);
        logic [1:0] r, w;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            r = 2'($urandom_range(1, 3));
            tx0[i] = 8'($urandom); tx1[i] = 8'($urandom); sb[i] = 8'($urandom);
            req[i] = r;
            w = arb(i, r);
            xfer(i, d, gap, k > 0, 0, w, w[1] ? tx1[i] : tx0[i], sb[i]);
        end
        req[i] = 2'b00;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_fast();
        test_req_drop();
        test_random(0, 4, 2);
        test_random(1, 1, 3);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_master_sched.md
# spi_master_sched

Single-clock SPI master that shares one SPI bus (SCK/SS/MOSI/MISO) between two on-chip requesters. It arbitrates requests, generates a mode-0 (CPOL=0, CPHA=0) SCK from PCLK, and runs one 8-bit MSB-first full-duplex transfer per grant. It returns the received byte and a per-requester completion pulse. It sits between the APB-side control logic and the external or on-chip SPI_SLAVE instances, which are configured for MODE 2'b00.

## Interface
- CLK_DIV, 4: PCLK cycles per SCK half-period; legal range 1..255.
- SS_GAP, 2: minimum PCLK cycles SS stays high between transfers; legal range 1..15.

- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- REQ  in  2  per-requester transfer request; level, held until GNT.
- TX_DATA0  in  8  byte to send for requester 0; sampled at grant edge.
- TX_DATA1  in  8  byte to send for requester 1; sampled at grant edge.
- GNT  out  2  one-hot, one-cycle pulse marking acceptance.
- DONE  out  2  one-hot, one-cycle pulse at transfer end.
- RX_DATA  out  8  received byte; valid from DONE until next DONE.
- BUSY  out  1  high from grant through end of SS gap.
- SCK  out  1  SPI clock; idles low.
- SS  out  1  active-low slave select.
- MOSI  out  1  serial data out, MSB first.
- MISO  in  1  serial data in.

## Operation
- All outputs are registered. Reset values:
  - SCK=0, SS=1, MOSI=0, GNT=0, DONE=0, RX_DATA=8'h00, BUSY=0.
  - The round-robin pointer resets to "last served = 1".
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- **IDLE**: if any REQ bit is high at an edge E0:
  - pick the winner and capture its TX_DATA into the shift register;
  - after E0: GNT[winner]=1 for one cycle, SS=0, MOSI=tx[7], BUSY=1; go to SETUP.
- **SETUP**: hold SCK=0 for CLK_DIV cycles, then drive SCK=1 and go to HIGH.
- **HIGH**: after CLK_DIV cycles, drive SCK=0. At that same edge:
  - sample MISO into RX bit 0, shifting RX left;
  - shift TX left so MOSI presents the next bit.
  - After 8 bits, go to HOLD; otherwise go to LOW.
- **LOW**: after CLK_DIV cycles, drive SCK=1 and go to HIGH.
- **HOLD**: SCK=0 for CLK_DIV cycles, then:
  - SS=1, RX_DATA updated, DONE[winner]=1 for one cycle, MOSI=0; go to GAP.
- **GAP**: SS_GAP cycles, then BUSY=0 and go to IDLE. REQ is evaluated at the next edge.
- REQ changes after GNT are ignored; the granted transfer always completes.
- REQ asserted while BUSY is held pending and is served after GAP.
- A requester re-asserting REQ immediately is still subject to arbitration against the other requester.
- PRESET at any cycle, including mid-transfer, returns to IDLE with reset values at the next edge. No DONE is produced and the aborted transfer is not resumed.

## Timing
- With E0 as the grant edge:
  - k-th SCK rise (k=1..8) at E0+(2k−1)·CLK_DIV.
  - k-th SCK fall at E0+2k·CLK_DIV.
  - SS rises and DONE pulses at E0+17·CLK_DIV.
  - Earliest next grant edge: E0+17·CLK_DIV+SS_GAP.
- SS is low for exactly 17·CLK_DIV cycles. SCK has exactly 8 rising edges while SS is low.
- MOSI is stable for at least CLK_DIV cycles before each SCK rise. MOSI changes only with SCK falls or SS transitions.
- Latency from REQ sampled to GNT: 1 cycle (registered).

## Configuration
- SPI_SCHED_RR_EN defined: round-robin arbitration.
  - On a tie, the requester not served last wins.
  - The pointer updates at each grant.
- Not defined: fixed priority. Requester 0 always wins a tie, and the pointer logic is absent.
- Both builds are identical when only one REQ bit is high.

## Test plan
- CLK_DIV=4, REQ=2'b01, TX_DATA0=8'hA5, MISO model returns 8'h3C:
  - MOSI at the 8 SCK rises = 1,0,1,0,0,1,0,1;
  - GNT=2'b01 at E0+1;
  - DONE=2'b01 and RX_DATA=8'h3C at E0+68;
  - SS low exactly 68 cycles.
- REQ=2'b11 held, TX_DATA0=8'h11, TX_DATA1=8'h22:
  - RR build grants 0,1,0,1 (MOSI bytes 11,22,11,22);
  - non-RR build grants 0,0,0,0.
  - Gap between SS rise and next SS fall is ≥SS_GAP=2 cycles.
- PRESET pulsed 1 cycle at E0+30:
  - next cycle SS=1, SCK=0, BUSY=0, RX_DATA=8'h00;
  - no DONE pulse;
  - a subsequent REQ gets a fresh full transfer.
- CLK_DIV=1, REQ=2'b10, TX_DATA1=8'hFF, MISO=0:
  - SCK toggles every cycle;
  - DONE=2'b10 at E0+17, RX_DATA=8'h00.
- REQ[0] dropped one cycle after GNT: the transfer still completes, with DONE[0] at E0+17·CLK_DIV.
